// File: rtl/alarm_bank.sv
// Multi-channel alarm manager: per-channel ring/snooze/stop FSMs.
// Optional beep modulation of Sound enabled by ALARM_BEEP_EN.
module alarm_bank #(
    parameter int N_ALARMS   = 4,
    parameter int SNOOZE_MIN = 9,
    parameter int RING_MIN   = 5,
    parameter int BEEP_W     = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                min_tick,
    input  logic [4:0]          cur_hour,
    input  logic [5:0]          cur_min,
    input  logic [2:0]          cur_day,
    input  logic                wr_en,
    input  logic [2:0]          wr_sel,
    input  logic [4:0]          wr_hour,
    input  logic [5:0]          wr_min,
    input  logic [6:0]          wr_days,
    input  logic                wr_on,
    input  logic                Snooze,
    input  logic                Stop,
    input  logic                Mute,
    output logic                Sound,
    output logic [N_ALARMS-1:0] ringing,
    output logic [N_ALARMS-1:0] snoozed,
    output logic                wr_err
);

    typedef enum logic [1:0] {
        S_DIS,
        S_ARM,
        S_RING,
        S_SNZ
    } state_t;

    localparam logic [3:0] RING_L = 4'(RING_MIN);
    localparam logic [3:0] SNZ_L  = 4'(SNOOZE_MIN);

    state_t     st_q [N_ALARMS];
    state_t     st_d [N_ALARMS];
    logic [4:0] hr_q [N_ALARMS];
    logic [4:0] hr_d [N_ALARMS];
    logic [5:0] mn_q [N_ALARMS];
    logic [5:0] mn_d [N_ALARMS];
    logic [6:0] dm_q [N_ALARMS];
    logic [6:0] dm_d [N_ALARMS];
    logic [3:0] rc_q [N_ALARMS];
    logic [3:0] rc_d [N_ALARMS];
    logic [3:0] sc_q [N_ALARMS];
    logic [3:0] sc_d [N_ALARMS];

    logic wr_valid;
    logic wr_ok;
    logic wr_err_q;
    logic beep_gate;

    assign wr_valid = ({1'b0, wr_sel} < 4'(N_ALARMS)) &&
                      (wr_hour <= 5'd23) && (wr_min <= 6'd59);
    assign wr_ok    = wr_en & wr_valid;

    always_comb begin
        logic [7:0] m8;
        logic       hit;
        st_d = st_q;
        hr_d = hr_q;
        mn_d = mn_q;
        dm_d = dm_q;
        rc_d = rc_q;
        sc_d = sc_q;
        m8   = '0;
        hit  = 1'b0;
        for (int i = 0; i < N_ALARMS; i++) begin
            m8  = {1'b0, dm_q[i]};
            hit = (hr_q[i] == cur_hour) && (mn_q[i] == cur_min) &&
                  (m8[cur_day] || (dm_q[i] == 7'd0));
            if (wr_ok && (wr_sel == 3'(i))) begin
                hr_d[i] = wr_hour;
                mn_d[i] = wr_min;
                dm_d[i] = wr_days;
                st_d[i] = wr_on ? S_ARM : S_DIS;
                rc_d[i] = '0;
                sc_d[i] = '0;
            end else if (Stop &&
                         (st_q[i] == S_RING || st_q[i] == S_SNZ)) begin
                st_d[i] = (dm_q[i] == 7'd0) ? S_DIS : S_ARM;
                rc_d[i] = '0;
                sc_d[i] = '0;
            end else if (Snooze && st_q[i] == S_RING) begin
                st_d[i] = S_SNZ;
                sc_d[i] = SNZ_L;
            end else if (min_tick) begin
                unique case (st_q[i])
                    S_ARM: begin
                        if (hit) begin
                            st_d[i] = S_RING;
                            rc_d[i] = '0;
                        end
                    end
                    S_RING: begin
                        rc_d[i] = rc_q[i] + 4'd1;
                        if (rc_q[i] + 4'd1 == RING_L) begin
                            st_d[i] = (dm_q[i] == 7'd0) ? S_DIS : S_ARM;
                            rc_d[i] = '0;
                        end
                    end
                    S_SNZ: begin
                        sc_d[i] = sc_q[i] - 4'd1;
                        if (sc_q[i] == 4'd1) begin
                            st_d[i] = S_RING;
                            rc_d[i] = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                st_q[i] <= S_DIS;
                hr_q[i] <= '0;
                mn_q[i] <= '0;
                dm_q[i] <= '0;
                rc_q[i] <= '0;
                sc_q[i] <= '0;
            end
            wr_err_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            hr_q     <= hr_d;
            mn_q     <= mn_d;
            dm_q     <= dm_d;
            rc_q     <= rc_d;
            sc_q     <= sc_d;
            wr_err_q <= wr_en & ~wr_valid;
        end
    end

    always_comb begin
        ringing = '0;
        snoozed = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            ringing[i] = (st_q[i] == S_RING);
            snoozed[i] = (st_q[i] == S_SNZ);
        end
    end

`ifdef ALARM_BEEP_EN
    logic [BEEP_W-1:0] beep_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            beep_q <= '0;
        end else begin
            beep_q <= beep_q + BEEP_W'(1);
        end
    end

    assign beep_gate = beep_q[BEEP_W-1];
`else
    logic [31:0] unused_beep_w;
    assign unused_beep_w = 32'(BEEP_W);
    assign beep_gate     = 1'b1;
`endif

    assign wr_err = wr_err_q;
    assign Sound  = (|ringing) & ~Mute & beep_gate;

endmodule

// File: doc/alarm_bank.md
# alarm_bank

- Multi-channel alarm manager for the alarm-clock datapath, replacing the single hard-wired alarm compare.
- Holds `N_ALARMS` programmable alarms, each with hour, minute and a weekday mask.
- Compares every alarm against the running time-of-day on each minute tick and runs a per-channel ring/snooze/stop state machine.
- Drives the shared `Sound` output and per-channel status to the display/control logic.

## Interface
Parameters:
- `N_ALARMS`, 4, number of alarm channels (1..8)
- `SNOOZE_MIN`, 9, minutes a snoozed channel waits before re-ringing (1..15)
- `RING_MIN`, 5, minutes a channel rings unattended before auto-stop (1..15)
- `BEEP_W`, 4, width of beep modulation counter (used only with `ALARM_BEEP_EN`)

Ports:
- `Clk`  in  1  system clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `min_tick`  in  1  one-`Clk` pulse at each minute rollover; `cur_*` already hold the new minute in that cycle
- `cur_hour`  in  5  current hour, 0..23
- `cur_min`  in  6  current minute, 0..59
- `cur_day`  in  3  current weekday, 0..6
- `wr_en`  in  1  one-cycle program strobe
- `wr_sel`  in  3  channel index to program
- `wr_hour`  in  5  alarm hour
- `wr_min`  in  6  alarm minute
- `wr_days`  in  7  weekday mask; all-zero means one-shot
- `wr_on`  in  1  1 = arm channel, 0 = disable channel
- `Snooze`  in  1  one-cycle pulse
- `Stop`  in  1  one-cycle pulse
- `Mute`  in  1  level; silences `Sound` without changing state
- `Sound`  out  1  buzzer drive
- `ringing`  out  N_ALARMS  per-channel RINGING flag
- `snoozed`  out  N_ALARMS  per-channel SNOOZED flag
- `wr_err`  out  1  one-cycle pulse on a rejected write

## Operation
Each channel has four states: DISABLED, ARMED, RINGING, SNOOZED. Each channel also has a 4-bit ring counter `rc` and a 4-bit snooze counter `sc`.

Programming:
- A write with `wr_sel < N_ALARMS`, `wr_hour <= 23` and `wr_min <= 59` loads the channel's hour, minute and mask.
- The channel then goes to ARMED if `wr_on` = 1, else DISABLED, from any state; `rc` and `sc` clear.
- An out-of-range field or `wr_sel >= N_ALARMS` leaves all state unchanged and pulses `wr_err`.

Transitions:
- **Match:** on `min_tick`, an ARMED channel with equal hour and minute, and either `wr_days[cur_day]` set or a zero mask, goes to RINGING with `rc` = 0.
- **RINGING:**
  - Each `min_tick` increments `rc`.
  - When `rc` reaches `RING_MIN`, the channel auto-stops: it goes to ARMED, or to DISABLED if the mask is zero.
- **Snooze:** all RINGING channels go to SNOOZED with `sc` = `SNOOZE_MIN`. Snooze is ignored if no channel is RINGING. Channels already SNOOZED are untouched.
- **SNOOZED:**
  - Each `min_tick` decrements `sc`.
  - On the tick where `sc` goes 1 to 0, the channel goes to RINGING with `rc` = 0.
- **Stop:** every RINGING or SNOOZED channel goes to ARMED, or to DISABLED if the mask is zero.

Priority when several events coincide on one channel:
1. write
2. `Stop`
3. `Snooze`
4. `min_tick`

Further rules for coincident events:
- `Snooze` with `min_tick` loads `SNOOZE_MIN` and does not decrement that cycle.
- A write and a match on the same channel in the same cycle produce no ring.

Sound: `Sound` = (|`ringing`) & ~`Mute`.

## Timing
- All state is registered. A match, command or write takes effect at the `Clk` edge that samples it; `ringing` and `snoozed` reflect it in the following cycle.
- `wr_err` is registered and asserts for exactly one cycle, the cycle after the bad strobe.
- `Sound` is combinational from registered `ringing` and the `Mute` input.
- Reset values while `Reset` = 0: all channels DISABLED, stored times 00:00, masks 0, counters 0, `ringing` = 0, `snoozed` = 0, `wr_err` = 0, `Sound` = 0.
- Reset asserted mid-ring clears immediately and asynchronously.
- Consecutive writes on back-to-back cycles are all accepted.

## Configuration
Macro: `ALARM_BEEP_EN`.
- **Defined:** a free-running `BEEP_W`-bit counter, reset to 0, increments every `Clk`. `Sound` is additionally ANDed with the counter MSB, giving a square-wave beep with period 2^`BEEP_W` cycles that starts low after reset.
- **Undefined:** no counter; `Sound` is steady while any channel rings.

## Test plan
- **Match:** program ch1 to 07:30, mask 0x3E, on; drive `min_tick` with 07:30, day 2 -> `ringing` = 0b0010 next cycle and `Sound` = 1. Repeat on day 0 -> no ring.
- **Snooze:** ch1 ringing, pulse `Snooze` -> `snoozed` = 0b0010 and `ringing` = 0. After 8 `min_tick`s still snoozed; on the 9th `ringing` = 0b0010.
- **Auto-stop and one-shot:** ring a one-shot channel for 5 `min_tick`s -> the channel is DISABLED and the same time on the next day does not ring. A masked channel under the same test returns to ARMED.
- **Coincident inputs:** `Stop` and `Snooze` in the same cycle with ch0 and ch2 ringing -> both ARMED, `snoozed` = 0. `Mute` = 1 while ringing -> `Sound` = 0 with `ringing` unchanged.
- **Bad writes:** `wr_hour` = 24, then `wr_sel` = 5 -> `wr_err` pulses once per write and the channels are unchanged. A write to a RINGING channel with `wr_on` = 0 -> DISABLED, `ringing` bit clears.
- **Reset mid-ring:** pull `Reset` low while ch3 is snoozed -> all outputs 0 without waiting for `Clk`. With `ALARM_BEEP_EN`, confirm `Sound` toggles every 8 cycles while ringing.
